// File: rtl/trace_reader_pkg.sv
// trace_reader shared constants, entry layout and bank geometry.
// Imported by the trace_reader top and its height_lut helper.
package trace_reader_pkg;

   // first screen column held in the buffer
   localparam int COL_BASE = 64;
   // wall half-height saturation, in rows
   localparam int H_MAX = 240;
   // entries per bank, and index width
   localparam int DEPTH = 512;
   localparam int IDX_W = 9;

   // vdist is UQ7.9: 512 == 1.0
   localparam int VDIST_FRAC = 9;
   localparam int VDIST_ONE = 1 << VDIST_FRAC;

   // h = H_NUM / vdist, i.e. 256 rows at distance 1.0
   localparam int H_NUM = 256 * VDIST_ONE;
   // largest vdist whose quotient still reaches H_MAX
   localparam int H_SAT_VDIST = H_NUM / H_MAX;

   // visible frame rows and horizon row
   localparam int V_VIS = 480;
   localparam int HORIZON = 240;

   // bank entry bit fields
   localparam int ENT_W = 15;
   localparam int ENT_H_LSB = 0;
   localparam int ENT_H_MSB = 7;
   localparam int ENT_TEX_LSB = 8;
   localparam int ENT_TEX_MSB = 13;
   localparam int ENT_SIDE = 14;

   typedef struct packed {
      logic       side;
      logic [5:0] tex;
      logic [7:0] h;
   } entry_t;

endpackage

// File: rtl/trace_reader_height_lut.sv
// height_lut: combinational wall half-height from UQ7.9 distance.
// Ports: i_vdist (distance), o_h (min(H_MAX, 131072/vdist)).
module height_lut
   import trace_reader_pkg::*;
(
   input  logic [15:0] i_vdist,
   output logic [7:0]  o_h
);

   // Eight-step restoring divide. Only used when vdist > H_SAT_VDIST,
   // where the quotient is below 256, so 8 quotient bits suffice.
   function automatic logic [7:0] recip(input logic [15:0] d);
      logic [24:0] rem;
      logic [24:0] dd;
      logic [7:0]  q;
      rem = 25'(H_NUM);
      q   = '0;
      for (int i = 7; i >= 0; i--) begin
         dd = 25'(d) << i;
         if (rem >= dd) begin
            rem  = rem - dd;
            q[i] = 1'b1;
         end
      end
      return q;
   endfunction

   logic w_sat;

   // vdist == 0 also falls in the saturated range
   assign w_sat = (i_vdist <= 16'(H_SAT_VDIST));
   assign o_h   = w_sat ? 8'(H_MAX) : recip(i_vdist);

endmodule

// File: rtl/trace_reader.sv
// trace_reader: ping-pong column buffer between tracer and VGA scan.
// Write side: store/column/side/vdist/tex. Control: swap.
// Read side: hpos/vpos in, wall/wall_side/wall_u/wall_dy/wall_h out
// three clocks later. Status: back_full, front_valid, swap_miss.
module trace_reader
   import trace_reader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        store,
   input  logic [9:0]  column,
   input  logic        side,
   input  logic [15:0] vdist,
   input  logic [5:0]  tex,
   input  logic        swap,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   output logic        wall,
   output logic        wall_side,
   output logic [5:0]  wall_u,
   output logic [7:0]  wall_dy,
   output logic [7:0]  wall_h,
   output logic        back_full,
   output logic        front_valid,
   output logic        swap_miss
);

   // two banks; sel is the top address bit of the front bank
   logic [ENT_W-1:0] r_bank [0:2*DEPTH-1];

   logic             r_sel;
   logic             r_back_full;
   logic             r_front_valid;
   logic             r_swap_miss;
   logic             r_swap_pend;

   // write stage W0
   logic             r_wpend;
   logic [IDX_W-1:0] r_w_idx;
   logic             r_w_side;
   logic [5:0]       r_w_tex;
   logic [15:0]      r_w_vdist;

   // read stages R0/R1
   logic             r_r0_valid;
   logic [IDX_W-1:0] r_r0_idx;
   logic [7:0]       r_r0_dy;
   logic             r_r1_valid;
   logic [7:0]       r_r1_dy;
   entry_t           r_r1_entry;

   // registered outputs (R2)
   logic             r_wall;
   logic             r_wall_side;
   logic [5:0]       r_wall_u;
   logic [7:0]       r_wall_dy;
   logic [7:0]       r_wall_h;

   logic [9:0]       w_col_off;
   logic             w_col_ok;
   logic             w_wr;
   logic             w_wr_last;
   logic             w_wpend_last;
   logic [7:0]       w_h;
   entry_t           w_entry;
   logic             w_defer;
   logic             w_swap_req;
   logic             w_full_eff;
   logic             w_accept;
   logic             w_reject;
   logic [9:0]       w_hoff;
   logic             w_rd_ok;
   logic [7:0]       w_dy;

   // ---------------- write path ----------------

   assign w_col_off = column - 10'(COL_BASE);
   assign w_col_ok  = (column >= 10'(COL_BASE))
                    && (w_col_off < 10'(DEPTH));
   assign w_wr      = store & w_col_ok;
   assign w_wr_last = w_wr
                    & (w_col_off[IDX_W-1:0] == IDX_W'(DEPTH-1));
   assign w_wpend_last = r_wpend
                       & (r_w_idx == IDX_W'(DEPTH-1));

   height_lut u_height_lut (
      .i_vdist (r_w_vdist),
      .o_h     (w_h)
   );

   assign w_entry = '{side: r_w_side, tex: r_w_tex, h: w_h};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wpend   <= 1'b0;
         r_w_idx   <= '0;
         r_w_side  <= 1'b0;
         r_w_tex   <= '0;
         r_w_vdist <= '0;
      end else begin
         r_wpend <= w_wr;
         if (w_wr) begin
            r_w_idx   <= w_col_off[IDX_W-1:0];
            r_w_side  <= side;
            r_w_tex   <= tex;
            r_w_vdist <= vdist;
         end
      end
   end

   // W1 always targets the back bank as seen in this cycle, so an
   // index-511 write landing with an accepted swap joins the old frame
   always_ff @(posedge clk) begin
      if (r_wpend)
         r_bank[{~r_sel, r_w_idx}] <= w_entry;
   end

   // ---------------- swap control ----------------

   // A fresh swap racing the index-511 write (still in W0 or W1) is
   // held one clock so the decision sees that write as landed.
   assign w_defer    = swap & ~r_swap_pend
                     & (w_wr_last | w_wpend_last);
   assign w_swap_req = (swap | r_swap_pend) & ~w_defer;
   assign w_full_eff = r_back_full | w_wpend_last;
   assign w_accept   = w_swap_req & w_full_eff;
   assign w_reject   = w_swap_req & ~w_full_eff;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel         <= 1'b0;
         r_back_full   <= 1'b0;
         r_front_valid <= 1'b0;
         r_swap_miss   <= 1'b0;
         r_swap_pend   <= 1'b0;
      end else begin
         r_swap_pend <= w_defer;
         if (w_accept) begin
            r_sel         <= ~r_sel;
            r_back_full   <= 1'b0;
            r_front_valid <= 1'b1;
         end else if (w_wpend_last) begin
            r_back_full <= 1'b1;
         end
         if (w_reject)
            r_swap_miss <= 1'b1;
      end
   end

   // ---------------- read path ----------------

   assign w_hoff  = hpos - 10'(COL_BASE);
   assign w_rd_ok = (hpos >= 10'(COL_BASE))
                  && (w_hoff < 10'(DEPTH))
                  && (vpos < 10'(V_VIS))
                  && r_front_valid;
   // distance from the horizon, symmetric about rows 239/240
   assign w_dy = (vpos < 10'(HORIZON))
               ? 8'(10'(HORIZON - 1) - vpos)
               : 8'(vpos - 10'(HORIZON));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_r0_valid <= 1'b0;
         r_r0_idx   <= '0;
         r_r0_dy    <= '0;
         r_r1_valid <= 1'b0;
         r_r1_dy    <= '0;
      end else begin
         r_r0_valid <= w_rd_ok;
         r_r0_idx   <= w_hoff[IDX_W-1:0];
         r_r0_dy    <= w_dy;
         r_r1_valid <= r_r0_valid;
         r_r1_dy    <= r_r0_dy;
      end
   end

   always_ff @(posedge clk) begin
      r_r1_entry <= entry_t'(r_bank[{r_sel, r_r0_idx}]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wall      <= 1'b0;
         r_wall_side <= 1'b0;
         r_wall_u    <= '0;
         r_wall_dy   <= '0;
         r_wall_h    <= '0;
      end else if (r_r1_valid) begin
         r_wall      <= (r_r1_dy < r_r1_entry.h);
         r_wall_side <= r_r1_entry.side;
         r_wall_u    <= r_r1_entry.tex;
         r_wall_dy   <= r_r1_dy;
         r_wall_h    <= r_r1_entry.h;
      end else begin
         r_wall      <= 1'b0;
         r_wall_side <= 1'b0;
         r_wall_u    <= '0;
         r_wall_dy   <= '0;
         r_wall_h    <= '0;
      end
   end

   assign wall        = r_wall;
   assign wall_side   = r_wall_side;
   assign wall_u      = r_wall_u;
   assign wall_dy     = r_wall_dy;
   assign wall_h      = r_wall_h;
   assign back_full   = r_back_full;
   assign front_valid = r_front_valid;
   assign swap_miss   = r_swap_miss;

endmodule

// File: tb/tb_trace_reader.sv
// tb_trace_reader: randomized bench for trace_reader against a
// frame-level reference model (two column arrays plus status flags).
module tb_trace_reader;

   typedef struct packed {
      logic       side;
      logic [5:0] tex;
      logic [7:0] h;
   } ent_t;

   typedef struct packed {
      logic       wall;
      logic       side;
      logic [5:0] u;
      logic [7:0] dy;
      logic [7:0] h;
   } pix_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        store;
   logic [9:0]  column;
   logic        side;
   logic [15:0] vdist;
   logic [5:0]  tex;
   logic        swap;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        wall;
   logic        wall_side;
   logic [5:0]  wall_u;
   logic [7:0]  wall_dy;
   logic [7:0]  wall_h;
   logic        back_full;
   logic        front_valid;
   logic        swap_miss;

   int errors = 0;
   int checks = 0;

   ent_t m_front [512];
   ent_t m_back  [512];
   bit   m_back_full;
   bit   m_front_valid;
   bit   m_swap_miss;

   trace_reader dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .store       (store),
      .column      (column),
      .side        (side),
      .vdist       (vdist),
      .tex         (tex),
      .swap        (swap),
      .hpos        (hpos),
      .vpos        (vpos),
      .wall        (wall),
      .wall_side   (wall_side),
      .wall_u      (wall_u),
      .wall_dy     (wall_dy),
      .wall_h      (wall_h),
      .back_full   (back_full),
      .front_valid (front_valid),
      .swap_miss   (swap_miss)
   );

   always #5 clk = ~clk;

   function automatic int ref_h(int vd);
      int q;
      if (vd == 0) return 240;
      q = 131072 / vd;
      return (q > 240) ? 240 : q;
   endfunction

   function automatic pix_t ref_pix(int hp, int vp);
      pix_t p;
      int   dy;
      ent_t e;
      p = '0;
      if (hp < 64 || hp > 575 || vp >= 480 || !m_front_valid)
         return p;
      dy = (vp < 240) ? 239 - vp : vp - 240;
      e  = m_front[hp-64];
      p.wall = (dy < int'(e.h));
      p.side = e.side;
      p.u    = e.tex;
      p.dy   = 8'(dy);
      p.h    = e.h;
      return p;
   endfunction

   function automatic int rnd_vdist();
      case ($urandom_range(0, 3))
         0:       return $urandom_range(0, 600);
         1:       return $urandom_range(600, 4000);
         default: return $urandom_range(0, 65535);
      endcase
   endfunction

   function automatic pix_t obs_pix();
      return {wall, wall_side, wall_u, wall_dy, wall_h};
   endfunction

   function automatic logic [2:0] obs_flags();
      return {back_full, front_valid, swap_miss};
   endfunction

   function automatic logic [2:0] exp_flags();
      return {m_back_full, m_front_valid, m_swap_miss};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_swap();
      ent_t t;
      if (m_back_full) begin
         for (int i = 0; i < 512; i++) begin
            t = m_front[i];
            m_front[i] = m_back[i];
            m_back[i] = t;
         end
         m_back_full   = 0;
         m_front_valid = 1;
      end else begin
         m_swap_miss = 1;
      end
   endtask

   task automatic do_store(input int col, input bit s,
                           input int vd, input int tx,
                           input bit sw);
      store  = 1'b1;
      column = 10'(col);
      side   = s;
      vdist  = 16'(vd);
      tex    = 6'(tx);
      swap   = sw;
      tick(1);
      store = 1'b0;
      swap  = 1'b0;
      if (col >= 64 && col <= 575) begin
         m_back[col-64] = '{s, 6'(tx), 8'(ref_h(vd))};
         if (col == 575) m_back_full = 1;
      end
      if (sw) model_swap();
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick(1);
      swap = 1'b0;
      model_swap();
   endtask

   task automatic fill_rand(input int lo, input int hi);
      for (int c = lo; c <= hi; c++)
         do_store(c, 1'($urandom), rnd_vdist(),
                  $urandom_range(0, 63), 1'b0);
   endtask

   task automatic read_pix(input int hp, input int vp,
                           output pix_t obs);
      hpos = 10'(hp);
      vpos = 10'(vp);
      tick(3);
      obs = obs_pix();
   endtask

   task automatic test_reset();
      pix_t obs;
      checks++;
      if (obs_pix() !== '0) begin
         errors++;
         $display("FAIL reset_pix got=%h want=0", obs_pix());
      end
      checks++;
      if (obs_flags() !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got=%b want=000", obs_flags());
      end
      read_pix(100, 240, obs);
      checks++;
      if (obs.wall !== 1'b0 || front_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_read got wall=%b fv=%b want 0 0",
                  obs.wall, front_valid);
      end
   endtask

   task automatic test_fill_fixed();
      pix_t obs;
      pix_t exp;
      for (int c = 64; c <= 575; c++)
         do_store(c, 1'b1, 1024, 5, 1'b0);
      tick(2);
      checks++;
      if (obs_flags() !== 3'b100) begin
         errors++;
         $display("FAIL fixed_full got=%b want=100", obs_flags());
      end
      do_swap();
      tick(1);
      checks++;
      if (obs_flags() !== 3'b010) begin
         errors++;
         $display("FAIL fixed_swap got=%b want=010", obs_flags());
      end
      read_pix(300, 200, obs);
      exp = '{1'b1, 1'b1, 6'd5, 8'd39, 8'd128};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL fixed_wall got=%h want=%h", obs, exp);
      end
      read_pix(300, 50, obs);
      exp = '{1'b0, 1'b1, 6'd5, 8'd189, 8'd128};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL fixed_sky got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_heights();
      pix_t obs;
      fill_rand(64, 575);
      do_store(100, 1'b0, 0, 1, 1'b0);
      do_store(101, 1'b1, 512, 2, 1'b0);
      do_store(102, 1'b0, 65535, 3, 1'b0);
      do_store(103, 1'b1, 2048, 4, 1'b0);
      tick(2);
      do_swap();
      read_pix(100, 240, obs);
      checks++;
      if (obs.h !== 8'd240) begin
         errors++;
         $display("FAIL h_vd0 got=%0d want=240", obs.h);
      end
      read_pix(101, 240, obs);
      checks++;
      if (obs.h !== 8'd240) begin
         errors++;
         $display("FAIL h_vd512 got=%0d want=240", obs.h);
      end
      read_pix(102, 240, obs);
      checks++;
      if (obs.h !== 8'd2 || obs.wall !== 1'b1) begin
         errors++;
         $display("FAIL h_vd65535 got=%h want h=2 wall=1", obs);
      end
      read_pix(103, 240, obs);
      checks++;
      if (obs.h !== 8'd64) begin
         errors++;
         $display("FAIL h_vd2048 got=%0d want=64", obs.h);
      end
   endtask

   task automatic test_random_pixels(input int n);
      pix_t obs;
      pix_t exp;
      int   hp;
      int   vp;
      for (int i = 0; i < n; i++) begin
         hp = $urandom_range(30, 620);
         vp = $urandom_range(0, 520);
         read_pix(hp, vp, obs);
         exp = ref_pix(hp, vp);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL rand_pix h=%0d v=%0d got=%h want=%h",
                     hp, vp, obs, exp);
         end
      end
   endtask

   task automatic test_swap_with_store();
      pix_t obs;
      pix_t exp;
      fill_rand(64, 574);
      tick(2);
      checks++;
      if (back_full !== 1'b0) begin
         errors++;
         $display("FAIL race_prefull got=%b want=0", back_full);
      end
      do_store(575, 1'b1, 3000, 42, 1'b1);
      tick(3);
      checks++;
      if (obs_flags() !== exp_flags()) begin
         errors++;
         $display("FAIL race_flags got=%b want=%b",
                  obs_flags(), exp_flags());
      end
      read_pix(575, 240, obs);
      exp = ref_pix(575, 240);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL race_col575 got=%h want=%h", obs, exp);
      end
      read_pix(64, 300, obs);
      exp = ref_pix(64, 300);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL race_col64 got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_back_to_back(input int n);
      pix_t q[$];
      pix_t exp;
      int   hp;
      int   vp;
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            hp = $urandom_range(40, 600);
            vp = $urandom_range(0, 500);
            hpos = 10'(hp);
            vpos = 10'(vp);
            q.push_back(ref_pix(hp, vp));
         end
         tick(1);
         if (i >= 2) begin
            exp = q.pop_front();
            checks++;
            if (obs_pix() !== exp) begin
               errors++;
               $display("FAIL stream_%0d got=%h want=%h",
                        i - 2, obs_pix(), exp);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      pix_t obs;
      pix_t exp;
      do_store(63, 1'b1, 700, 9, 1'b0);
      do_store(20, 1'b1, 700, 9, 1'b0);
      do_store(600, 1'b1, 700, 9, 1'b0);
      tick(2);
      checks++;
      if (back_full !== 1'b0) begin
         errors++;
         $display("FAIL oor_full got=%b want=0", back_full);
      end
      fill_rand(64, 575);
      do_store(20, 1'b0, 555, 63, 1'b0);
      do_store(600, 1'b0, 555, 63, 1'b0);
      tick(2);
      checks++;
      if (back_full !== 1'b1) begin
         errors++;
         $display("FAIL oor_keepfull got=%b want=1", back_full);
      end
      do_swap();
      read_pix(88, 240, obs);
      exp = ref_pix(88, 240);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL oor_col88 got=%h want=%h", obs, exp);
      end
      read_pix(532, 240, obs);
      exp = ref_pix(532, 240);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL oor_col532 got=%h want=%h", obs, exp);
      end
      read_pix(10, 240, obs);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL oor_hpos10 got=%h want=0", obs);
      end
   endtask

   task automatic test_swap_miss();
      pix_t obs;
      pix_t exp;
      fill_rand(64, 400);
      tick(2);
      do_swap();
      tick(1);
      checks++;
      if (obs_flags() !== 3'b011) begin
         errors++;
         $display("FAIL miss_flags got=%b want=011", obs_flags());
      end
      read_pix(300, 240, obs);
      exp = ref_pix(300, 240);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL miss_oldframe got=%h want=%h", obs, exp);
      end
      test_random_pixels(6);
   endtask

   task automatic test_reset_midframe();
      pix_t obs;
      fill_rand(64, 200);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      m_back_full   = 0;
      m_front_valid = 0;
      m_swap_miss   = 0;
      #1;
      checks++;
      if (obs_flags() !== 3'b000 || obs_pix() !== '0) begin
         errors++;
         $display("FAIL async_reset got f=%b p=%h want 000 0",
                  obs_flags(), obs_pix());
      end
      #2;
      reset_n = 1'b1;
      tick(1);
      read_pix(300, 240, obs);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL post_reset_read got=%h want=0", obs);
      end
      fill_rand(64, 575);
      tick(2);
      do_swap();
      tick(1);
      checks++;
      if (obs_flags() !== 3'b010) begin
         errors++;
         $display("FAIL refill_flags got=%b want=010", obs_flags());
      end
      test_random_pixels(8);
   endtask

   initial begin
      reset_n = 1'b0;
      store   = 1'b0;
      column  = '0;
      side    = 1'b0;
      vdist   = '0;
      tex     = '0;
      swap    = 1'b0;
      hpos    = '0;
      vpos    = '0;
      m_back_full   = 0;
      m_front_valid = 0;
      m_swap_miss   = 0;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      test_reset();
      test_fill_fixed();
      test_heights();
      test_random_pixels(16);
      test_swap_with_store();
      test_back_to_back(40);
      test_out_of_range();
      test_swap_miss();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trace_reader.md
# trace_reader

Consumer end of the tracer's trace-buffer write interface. Captures per-column `{side, vdist, tex}` results into a ping-pong pair of 512-entry banks, converts distance to wall half-height at write time, and serves the VGA scan one pixel per clock. The display always reads a complete frame while the tracer fills the other bank. It sits between `tracer` and the pixel-colour logic.

## Interface
- `COL_BASE`, 64: first screen column covered by the buffer; the buffer spans `COL_BASE`..`COL_BASE+511`.
- `H_MAX`, 240: wall half-height saturation value, in rows.
- `clk` in 1: pixel clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `store` in 1: tracer write strobe, one clock wide.
- `column` in 10: screen column of the write.
- `side` in 1: wall side of the hit.
- `vdist` in 16: UQ7.9 perpendicular wall distance.
- `tex` in 6: texture u coordinate.
- `swap` in 1: one-clock request to present the back bank.
- `hpos` in 10, `vpos` in 10: current VGA scan position.
- `wall` out 1: current pixel is wall.
- `wall_side` out 1: side of the wall for this pixel.
- `wall_u` out 6: texture u for this pixel.
- `wall_dy` out 8: row distance from the horizon.
- `wall_h` out 8: half-height for this column.
- `back_full` out 1: back bank has received its index-511 write since the last swap.
- `front_valid` out 1: at least one swap has succeeded since reset.
- `swap_miss` out 1: sticky; set when a swap is rejected.

## Operation
- Index mapping: `idx = column - COL_BASE`. A write whose `column` lies outside `[COL_BASE, COL_BASE+511]` is dropped and has no side effects.
- Height calculation: `h = min(H_MAX, floor(131072 / vdist))`. `vdist == 0` gives `H_MAX`.
- Example heights: vdist 512 gives 240 (saturated), 1024 gives 128, 2048 gives 64, 65535 gives 2.
- Bank entry: 15 bits, `{side, tex, h[7:0]}`.
- Write pipeline, stage W0: register `{idx, side, tex, vdist}` when `store` is high and the column is in range. Sets `wpend`.
- Write pipeline, stage W1: compute `h` and write the entry into bank `~sel`. Clears `wpend`. If `idx == 511`, sets `back_full`.
- Swap is accepted only when `back_full == 1`. On acceptance: `sel` toggles, `back_full` clears, `front_valid` sets.
- Swap while `back_full == 0`: `sel` does not change, and `swap_miss` is set (sticky until reset).
- Swap in the same cycle as a write to index 511 (`wpend` is high): the acceptance decision is deferred one clock. By then the index-511 write has landed in the old back bank and `back_full` is set, so the swap is accepted.
- A `store` arriving in the cycle a swap toggles `sel` lands in the new back bank.
- Read pipeline, stage R0: register `ridx = hpos - COL_BASE`. Set `rvalid` when hpos is in range, `vpos < 480`, and `front_valid` is set. Register `dy = (vpos < 240) ? 239 - vpos : vpos - 240`, taking the low 8 bits.
- Read pipeline, stage R1: read bank `sel` at `ridx` (synchronous read) and carry `rvalid` and `dy` forward.
- Read pipeline, stage R2 (registered outputs): `wall = rvalid & (dy < h)`. `wall_side`, `wall_u` and `wall_h` come from the entry; `wall_dy = dy`. When `rvalid == 0`, all five outputs are 0.
- Banks are not reset. Their contents are don't-care until written; `front_valid` gates any use of them.

## Timing
- Reset values: all outputs 0. `sel = 0`, `wpend = 0`, pipeline valid bits 0.
- Reset mid-frame: asynchronous clear of all flags. The next frame must be fully rewritten and swapped before `front_valid` rises again.
- Write latency: `store` at cycle N becomes readable in the back bank at N+2. The tracer store rate is at most one every 4 clocks, but the pipeline accepts one per clock.
- Read latency: 3 clocks from `hpos`/`vpos` to the `wall*` outputs. The display delays hsync, vsync and blank by 3 clocks to match.
- `sel` changes only on an accepted swap. Downstream issues `swap` at the start of VBLANK, while the read pipeline is idle, so a visible frame never mixes banks.

## Structure
- Shared package: `COL_BASE`, `H_MAX`, the 512-entry depth, the UQ7.9 `vdist` format constant, and the entry bit-field positions.
- Single sub-module `height_lut`: combinational `vdist` → `h` with saturation, instanced in W1. It is unit-testable on its own.
- The two banks are inferred `reg [14:0] bank [0:1023]`, with `sel` as the top address bit.

## Test plan
- Reset release, then `hpos=100`, `vpos=240`: `wall=0` and `front_valid=0`, even with stale bank contents.
- Fill columns 64..575 with `vdist=1024`, `side=1`, `tex=5`, then swap. At `hpos=300`: `vpos=200` (dy=39) gives `wall=1`, `wall_h=128`, `wall_u=5`, `wall_side=1`, 3 clocks after the inputs. `vpos=50` (dy=189) gives `wall=0`.
- `vdist=0` and `vdist=512` both give `wall_h=240`. `vdist=65535` gives `wall_h=2`.
- Swap after filling only columns 64..400: `sel` is unchanged, `swap_miss=1`, and reads still return the previous frame.
- `swap` in the same cycle as `store` to column 575: the swap is accepted one clock later, and column 575 of the new front bank reads the stored value.
- `store` to column 20 and to column 600: no bank change and `back_full` unaffected. `hpos=10` gives `wall=0`.
